// File: rtl/adc_capture_pkg.sv
// Shared types and default sizing for the ADC capture buffer.
// The {ch2, ch1} word-width helper keeps the RAM and the top level in agreement.
package adc_capture_pkg;

  localparam int ZMOD_DATA_SIZE_DEF = 14;
  localparam int DEPTH_LOG2_DEF     = 10;
  localparam int DECIM_WIDTH_DEF    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_INIT,
    ST_ARMED,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  function automatic int word_width(input int sample_w);
    return 2 * sample_w;
  endfunction

endpackage

// File: rtl/adc_capture_ram.sv
// Frame store: one write port and one registered read port.
// There is no reset, so the array maps onto block RAM.
module adc_capture_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 28
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_data_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/adc_capture_buffer.sv
// Decimating, optionally triggered frame capture of both ADC channels into RAM,
// with a one-cycle-latency readback port serviced only while idle or done.
module adc_capture_buffer
  import adc_capture_pkg::*;
#(
  parameter int ZMOD_DATA_SIZE = ZMOD_DATA_SIZE_DEF,
  parameter int DEPTH_LOG2     = DEPTH_LOG2_DEF,
  parameter int DECIM_WIDTH    = DECIM_WIDTH_DEF
) (
  input  logic                        i_sys_clock,
  input  logic                        i_reset,
  input  logic                        i_adc_init_done,
  input  logic [ZMOD_DATA_SIZE-1:0]   i_adc_data_ch1,
  input  logic [ZMOD_DATA_SIZE-1:0]   i_adc_data_ch2,
  input  logic                        i_capture_start,
  input  logic [DECIM_WIDTH-1:0]      i_decimation,
  input  logic                        i_trig_enable,
  input  logic [ZMOD_DATA_SIZE-1:0]   i_trig_level,
  input  logic                        i_rd_req,
  input  logic [DEPTH_LOG2-1:0]       i_rd_addr,
  output logic [2*ZMOD_DATA_SIZE-1:0] o_rd_data,
  output logic                        o_rd_valid,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_abort
);

  localparam int WORD_W = word_width(ZMOD_DATA_SIZE);

  state_e                            state_q, state_d;
  logic [DECIM_WIDTH-1:0]            decim_q, decim_d;
  logic [DECIM_WIDTH-1:0]            cnt_q, cnt_d;
  logic                              trig_en_q, trig_en_d;
  logic signed [ZMOD_DATA_SIZE-1:0]  level_q, level_d;
  logic signed [ZMOD_DATA_SIZE-1:0]  prev_q, prev_d;
  logic                              prev_valid_q, prev_valid_d;
  logic [DEPTH_LOG2-1:0]             waddr_q, waddr_d;
  logic                              abort_q, abort_d;
  logic                              rd_valid_q;
  logic [WORD_W-1:0]                 ram_rd_data;

  logic start_ok, rd_ok, active, init_lost, strobe, fire, wr_en, wr_last;

  assign start_ok  = i_capture_start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign rd_ok     = i_rd_req && (state_q == ST_IDLE || state_q == ST_DONE);
  assign active    = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  assign init_lost = active && !i_adc_init_done;
  assign strobe    = active && (cnt_q == '0);
  assign fire      = !trig_en_q ||
                     (prev_valid_q && (prev_q < level_q) &&
                      ($signed(i_adc_data_ch1) >= level_q));
  // Losing init_done suppresses the write of that cycle's sample.
  assign wr_en     = strobe && !init_lost &&
                     ((state_q == ST_CAPTURE) || (state_q == ST_ARMED && fire));
  assign wr_last   = &waddr_q;

  always_ff @(posedge i_sys_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) state_d = i_adc_init_done ? ST_ARMED : ST_WAIT_INIT;
      end
      ST_WAIT_INIT: begin
        if (i_adc_init_done) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (init_lost)  state_d = ST_IDLE;
        else if (wr_en) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (init_lost)             state_d = ST_IDLE;
        else if (wr_en && wr_last) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state_q == ST_WAIT_INIT) || (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    o_done = (state_q == ST_DONE);
  end

  always_comb begin
    decim_d      = decim_q;
    trig_en_d    = trig_en_q;
    level_d      = level_q;
    cnt_d        = cnt_q;
    waddr_d      = waddr_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    abort_d      = abort_q;
    if (start_ok) begin
      decim_d      = i_decimation;
      trig_en_d    = i_trig_enable;
      level_d      = $signed(i_trig_level);
      cnt_d        = '0;
      waddr_d      = '0;
      prev_valid_d = 1'b0;
      abort_d      = 1'b0;
    end else begin
      if (active) cnt_d = strobe ? decim_q : cnt_q - DECIM_WIDTH'(1);
      if (init_lost) abort_d = 1'b1;
      if (strobe && state_q == ST_ARMED && trig_en_q) begin
        prev_d       = $signed(i_adc_data_ch1);
        prev_valid_d = 1'b1;
      end
      // The address parks on the last slot instead of wrapping.
      if (wr_en && !wr_last) waddr_d = waddr_q + DEPTH_LOG2'(1);
    end
  end

  always_ff @(posedge i_sys_clock or posedge i_reset) begin
    if (i_reset) begin
      decim_q      <= '0;
      trig_en_q    <= 1'b0;
      level_q      <= '0;
      cnt_q        <= '0;
      waddr_q      <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      abort_q      <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      decim_q      <= decim_d;
      trig_en_q    <= trig_en_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      waddr_q      <= waddr_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      abort_q      <= abort_d;
      rd_valid_q   <= rd_ok;
    end
  end

  adc_capture_ram #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (WORD_W)
  ) u_ram (
    .clk       (i_sys_clock),
    .wr_en_i   (wr_en),
    .wr_addr_i (waddr_q),
    .wr_data_i ({i_adc_data_ch2, i_adc_data_ch1}),
    .rd_en_i   (rd_ok),
    .rd_addr_i (i_rd_addr),
    .rd_data_o (ram_rd_data)
  );

  // RAM output is not reset, so data is gated to zero outside valid cycles.
  assign o_rd_data  = rd_valid_q ? ram_rd_data : '0;
  assign o_rd_valid = rd_valid_q;
  assign o_abort    = abort_q;

endmodule
